xor_neuron_sched: RTL and testbench

//  Sequencer that runs the 3-neuron XOR network (hidden z1, hidden z2, output) on ONE shared

---
 rtl/xor_neuron_sched.sv | 198 +++++++++++++++++++
 tb/tb_xor_neuron_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_neuron_sched.sv
// Time-shared sequencer for a 3-neuron XOR network: z1, z2 and output evaluated on one
// external perceptron through a req/ack handshake, 4 patterns x 3 neurons, back-to-back.
module xor_neuron_sched #(
    parameter int              TAM     = 16,
    parameter logic [TAM-1:0]  ONE     = 16'h1000,
    parameter int              TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [3:0]     x1_pat,
    input  logic [3:0]     x2_pat,
    input  logic [TAM-1:0] w01,
    input  logic [TAM-1:0] w11,
    input  logic [TAM-1:0] w21,
    input  logic [TAM-1:0] w02,
    input  logic [TAM-1:0] w12,
    input  logic [TAM-1:0] w22,
    input  logic [TAM-1:0] w0,
    input  logic [TAM-1:0] w1,
    input  logic [TAM-1:0] w2,
    output logic           n_req,
    output logic [TAM-1:0] n_in1,
    output logic [TAM-1:0] n_in2,
    output logic [TAM-1:0] n_w0,
    output logic [TAM-1:0] n_w1,
    output logic [TAM-1:0] n_w2,
    input  logic           n_ack,
    input  logic           n_fire,
    output logic [3:0]     r1,
    output logic [3:0]     r2,
    output logic [3:0]     result,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           p_q, p_d;
    logic [1:0]           k_q, k_d;
    logic [3:0]           x1_q, x1_d, x2_q, x2_d;
    logic [3:0]           r1_q, r1_d, r2_q, r2_d, res_q, res_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [8:0][TAM-1:0]  w_q, w_d;
    logic [8:0][TAM-1:0]  w_in;
    logic                 hs;
    logic                 timeout_hit;
    logic                 last_eval;

    // Weight slots: 0..2 = z1 (bias,in1,in2), 3..5 = z2, 6..8 = output neuron.
    assign w_in = {w2, w1, w0, w22, w12, w02, w21, w11, w01};

    assign hs          = (state_q == S_EVAL) && n_ack;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign last_eval   = (p_q == 2'd3) && (k_q == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            k_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: state_d = S_EVAL;
            S_EVAL: begin
                if (hs && last_eval)
                    state_d = S_DONE;
                else if (!hs && timeout_hit)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        p_d   = p_q;
        k_d   = k_q;
        x1_d  = x1_q;
        x2_d  = x2_q;
        r1_d  = r1_q;
        r2_d  = r2_q;
        res_d = res_q;
        err_d = err_q;
        cnt_d = cnt_q;
        w_d   = w_q;
        case (state_q)
            S_LOAD: begin
                x1_d  = x1_pat;
                x2_d  = x2_pat;
                w_d   = w_in;
                r1_d  = '0;
                r2_d  = '0;
                res_d = '0;
                err_d = 1'b0;
                p_d   = '0;
                k_d   = '0;
                cnt_d = '0;
            end
            S_EVAL: begin
                if (hs) begin
                    cnt_d = '0;
                    case (k_q)
                        2'd0:    r1_d[p_q]  = n_fire;
                        2'd1:    r2_d[p_q]  = n_fire;
                        default: res_d[p_q] = n_fire;
                    endcase
                    if (k_q == 2'd2) begin
                        k_d = 2'd0;
                        p_d = p_q + 2'd1;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Operands are a pure function of held state, so they stay stable through ack waits.
    always_comb begin
        n_req  = (state_q == S_EVAL);
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        n_in1  = '0;
        n_in2  = '0;
        n_w0   = '0;
        n_w1   = '0;
        n_w2   = '0;
        if (state_q == S_EVAL) begin
            case (k_q)
                2'd0: begin
                    n_in1 = x1_q[p_q] ? ONE : '0;
                    n_in2 = x2_q[p_q] ? ONE : '0;
                    n_w0  = w_q[0];
                    n_w1  = w_q[1];
                    n_w2  = w_q[2];
                end
                2'd1: begin
                    n_in1 = x1_q[p_q] ? ONE : '0;
                    n_in2 = x2_q[p_q] ? ONE : '0;
                    n_w0  = w_q[3];
                    n_w1  = w_q[4];
                    n_w2  = w_q[5];
                end
                default: begin
                    n_in1 = r1_q[p_q] ? ONE : '0;
                    n_in2 = r2_q[p_q] ? ONE : '0;
                    n_w0  = w_q[6];
                    n_w1  = w_q[7];
                    n_w2  = w_q[8];
                end
            endcase
        end
    end

    assign r1     = r1_q;
    assign r2     = r2_q;
    assign result = res_q;
    assign err    = err_q;

endmodule

// File: tb/tb_xor_neuron_sched.sv
// Bench for xor_neuron_sched: behavioural perceptron responder plus a pattern-level XOR
// network model; scenario tasks compare run observations against the model.
module tb_xor_neuron_sched;

    localparam logic [15:0] ONE  = 16'h1000;
    localparam int          MAXC = 200;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [3:0]  x1_pat, x2_pat;
    logic [15:0] w01, w11, w21, w02, w12, w22, w0, w1, w2;
    logic        n_req, n_ack, n_fire;
    logic [15:0] n_in1, n_in2, n_w0, n_w1, n_w2;
    logic [3:0]  r1, r2, result;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    int     ack_mode  = 0;   // 0 tied high, 1 ack after ack_delay wait cycles, 2 never
    int     ack_delay = 0;
    int     wcnt      = 0;
    logic   noise     = 1'b0;
    longint acc;

    logic [15:0] mw [9];
    logic [3:0]  mx1, mx2, exp_r1, exp_r2, exp_res;
    logic [15:0] exp_ops [12][5];
    logic [15:0] obs_ops [12][5];
    int          obs_hs, obs_done_edge, obs_done_cnt, obs_stab;
    logic        obs_busy_after, obs_req_at_done, obs_err_at_done;

    xor_neuron_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x1_pat(x1_pat), .x2_pat(x2_pat),
        .w01(w01), .w11(w11), .w21(w21), .w02(w02), .w12(w12), .w22(w22),
        .w0(w0), .w1(w1), .w2(w2),
        .n_req(n_req), .n_in1(n_in1), .n_in2(n_in2), .n_w0(n_w0), .n_w1(n_w1), .n_w2(n_w2),
        .n_ack(n_ack), .n_fire(n_fire), .r1(r1), .r2(r2), .result(result),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Shared perceptron: fires iff w0 + w1*in1 + w2*in2 >= 0 in Q3.12.
    always_comb begin
        acc = longint'($signed(n_w0)) * 4096
            + longint'($signed(n_w1)) * longint'($signed(n_in1))
            + longint'($signed(n_w2)) * longint'($signed(n_in2));
        if (ack_mode == 0)
            n_ack = 1'b1;
        else if (ack_mode == 1)
            n_ack = n_req && (wcnt >= ack_delay);
        else
            n_ack = 1'b0;
        n_fire = (n_req && n_ack) ? (acc >= 0) : noise;
    end

    always @(posedge clk) begin
        noise <= 1'($urandom);
        if (n_req && !n_ack) wcnt <= wcnt + 1;
        else                 wcnt <= 0;
    end

    function automatic bit ref_fire(input logic [15:0] b, input logic [15:0] a1,
                                    input logic [15:0] a2, input bit i1, input bit i2);
        int s;
        s = int'($signed(b)) + (i1 ? int'($signed(a1)) : 0) + (i2 ? int'($signed(a2)) : 0);
        return s >= 0;
    endfunction

    // Drive the ports from mx1/mx2/mw and derive the expected network behaviour.
    task automatic apply_cfg();
        x1_pat = mx1; x2_pat = mx2;
        w01 = mw[0]; w11 = mw[1]; w21 = mw[2];
        w02 = mw[3]; w12 = mw[4]; w22 = mw[5];
        w0  = mw[6]; w1  = mw[7]; w2  = mw[8];
        for (int p = 0; p < 4; p++) begin
            bit h1, h2, o;
            h1 = ref_fire(mw[0], mw[1], mw[2], mx1[p], mx2[p]);
            h2 = ref_fire(mw[3], mw[4], mw[5], mx1[p], mx2[p]);
            o  = ref_fire(mw[6], mw[7], mw[8], h1, h2);
            exp_r1[p] = h1; exp_r2[p] = h2; exp_res[p] = o;
            for (int k = 0; k < 3; k++) begin
                exp_ops[3*p+k][0] = (k == 2) ? (h1 ? ONE : 16'h0) : (mx1[p] ? ONE : 16'h0);
                exp_ops[3*p+k][1] = (k == 2) ? (h2 ? ONE : 16'h0) : (mx2[p] ? ONE : 16'h0);
                exp_ops[3*p+k][2] = mw[3*k];
                exp_ops[3*p+k][3] = mw[3*k+1];
                exp_ops[3*p+k][4] = mw[3*k+2];
            end
        end
    endtask

    task automatic t1_cfg();
        mx1 = 4'b0101; mx2 = 4'b0011;
        mw[0] = 16'hF800; mw[1] = 16'h1000; mw[2] = 16'h1000;
        mw[3] = 16'h1800; mw[4] = 16'hF000; mw[5] = 16'hF000;
        mw[6] = 16'hE800; mw[7] = 16'h1000; mw[8] = 16'h1000;
        apply_cfg();
    endtask

    task automatic rand_cfg();
        mx1 = 4'($urandom); mx2 = 4'($urandom);
        for (int i = 0; i < 9; i++) mw[i] = 16'($urandom);
        apply_cfg();
    endtask

    // One run: pulse start, then observe at every falling edge (n = edges since start sampled).
    task automatic do_run(input int perturb_n);
        logic [15:0] cur[5];
        logic [15:0] prv[5];
        bit          prev_wait;
        obs_hs = 0; obs_done_edge = -1; obs_done_cnt = 0; obs_stab = 0;
        obs_busy_after = 1'bx; obs_req_at_done = 1'bx; obs_err_at_done = 1'bx;
        prev_wait = 1'b0;
        for (int i = 0; i < 5; i++) prv[i] = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < MAXC; n++) begin
            if (n == perturb_n) begin
                start = 1'b1;
                x1_pat = 4'($urandom); x2_pat = 4'($urandom);
                w01 = 16'($urandom); w11 = 16'($urandom); w21 = 16'($urandom);
                w02 = 16'($urandom); w12 = 16'($urandom); w22 = 16'($urandom);
                w0  = 16'($urandom); w1  = 16'($urandom); w2  = 16'($urandom);
            end else if (n == perturb_n + 1) begin
                start = 1'b0;
            end
            cur[0] = n_in1; cur[1] = n_in2; cur[2] = n_w0; cur[3] = n_w1; cur[4] = n_w2;
            if (n_req && prev_wait && (cur != prv)) obs_stab++;
            if (n_req && n_ack) begin
                if (obs_hs < 12) obs_ops[obs_hs] = cur;
                obs_hs++;
            end
            if (done) begin
                obs_done_cnt++;
                if (obs_done_edge < 0) begin
                    obs_done_edge = n; obs_req_at_done = n_req; obs_err_at_done = err;
                end
            end
            if (obs_done_edge >= 0 && n == obs_done_edge + 1) obs_busy_after = busy;
            if (obs_done_edge >= 0 && n == obs_done_edge + 4) break;
            prev_wait = n_req && !n_ack;
            prv = cur;
            @(negedge clk);
        end
        start = 1'b0;
        $display("run: hs=%0d done_edge=%0d dones=%0d r1=%b r2=%b result=%b err=%b",
                 obs_hs, obs_done_edge, obs_done_cnt, r1, r2, result, err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ack_mode = 0;
        t1_cfg();
        repeat (2) @(negedge clk);
        checks++;
        if ({n_req, busy, done, err, r1, r2, result, n_in1, n_w0} !== '0) begin
            errors++;
            $display("FAIL reset_state: got req=%b busy=%b done=%b err=%b r1=%b r2=%b res=%b in1=%h w0=%h, want all 0",
                     n_req, busy, done, err, r1, r2, result, n_in1, n_w0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        ack_mode = 0;
        t1_cfg();
        do_run(-1);
        checks++;
        if ({r1, r2, result} !== {4'b0111, 4'b1110, 4'b0110}) begin
            errors++;
            $display("FAIL t1_results: got r1=%b r2=%b result=%b, want 0111 1110 0110", r1, r2, result);
        end
        checks++;
        if (obs_done_edge !== 13 || obs_done_cnt !== 1) begin
            errors++;
            $display("FAIL t1_latency: got done_edge=%0d pulses=%0d, want 13 and 1", obs_done_edge, obs_done_cnt);
        end
        checks++;
        if (err !== 1'b0 || obs_busy_after !== 1'b0 || obs_req_at_done !== 1'b0) begin
            errors++;
            $display("FAIL t1_status: got err=%b busy_after=%b req_at_done=%b, want 0 0 0",
                     err, obs_busy_after, obs_req_at_done);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_ops[i] != exp_ops[i]) begin
                errors++;
                $display("FAIL t1_operands[%0d]: got %h %h %h %h %h, want %h %h %h %h %h", i,
                         obs_ops[i][0], obs_ops[i][1], obs_ops[i][2], obs_ops[i][3], obs_ops[i][4],
                         exp_ops[i][0], exp_ops[i][1], exp_ops[i][2], exp_ops[i][3], exp_ops[i][4]);
            end
        end
    endtask

    task automatic test_ack_wait();
        ack_mode = 1; ack_delay = 3;
        t1_cfg();
        do_run(-1);
        checks++;
        if ({r1, r2, result} !== {exp_r1, exp_r2, exp_res}) begin
            errors++;
            $display("FAIL t2_results: got %b %b %b, want %b %b %b", r1, r2, result, exp_r1, exp_r2, exp_res);
        end
        checks++;
        if (obs_done_edge !== 49 || obs_stab !== 0 || obs_hs !== 12) begin
            errors++;
            $display("FAIL t2_timing: got done_edge=%0d unstable=%0d hs=%0d, want 49 0 12",
                     obs_done_edge, obs_stab, obs_hs);
        end
    endtask

    task automatic test_timeout();
        ack_mode = 2;
        t1_cfg();
        do_run(-1);
        checks++;
        if (obs_done_edge !== 65 || obs_err_at_done !== 1'b1 || obs_req_at_done !== 1'b0) begin
            errors++;
            $display("FAIL t3_timeout: got done_edge=%0d err=%b req=%b, want 65 1 0",
                     obs_done_edge, obs_err_at_done, obs_req_at_done);
        end
        checks++;
        if ({r1, r2, result} !== 12'h000 || obs_busy_after !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL t3_state: got r1=%b r2=%b res=%b busy_after=%b err=%b, want 0s, busy 0, err 1",
                     r1, r2, result, obs_busy_after, err);
        end
    endtask

    task automatic test_busy_ignore();
        ack_mode = 0;
        t1_cfg();
        do_run(5);
        checks++;
        if ({r1, r2, result} !== {4'b0111, 4'b1110, 4'b0110} || err !== 1'b0) begin
            errors++;
            $display("FAIL t4_results: got %b %b %b err=%b, want 0111 1110 0110 err 0", r1, r2, result, err);
        end
        checks++;
        if (obs_done_cnt !== 1 || obs_done_edge !== 13) begin
            errors++;
            $display("FAIL t4_done: got pulses=%0d edge=%0d, want 1 and 13", obs_done_cnt, obs_done_edge);
        end
    endtask

    task automatic test_midrun_reset();
        ack_mode = 0;
        t1_cfg();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (r1 !== (exp_r1 & 4'b0011) || result !== (exp_res & 4'b0011) || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_partial: got r1=%b res=%b busy=%b, want %b %b 1",
                     r1, result, busy, exp_r1 & 4'b0011, exp_res & 4'b0011);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({n_req, busy, done, err, r1, r2, result, n_in1, n_w0} !== '0) begin
            errors++;
            $display("FAIL t5_async_reset: got req=%b busy=%b err=%b r1=%b r2=%b res=%b in1=%h, want all 0",
                     n_req, busy, err, r1, r2, result, n_in1);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_run(-1);
        checks++;
        if ({r1, r2, result} !== {4'b0111, 4'b1110, 4'b0110} || obs_done_edge !== 13) begin
            errors++;
            $display("FAIL t5_rerun: got %b %b %b edge=%0d, want 0111 1110 0110 edge 13",
                     r1, r2, result, obs_done_edge);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            ack_mode  = 1;
            ack_delay = $urandom_range(0, 4);
            rand_cfg();
            do_run(-1);
            checks++;
            if ({r1, r2, result} !== {exp_r1, exp_r2, exp_res} || err !== 1'b0) begin
                errors++;
                $display("FAIL rand_results[%0d]: got %b %b %b err=%b, want %b %b %b err 0", it,
                         r1, r2, result, err, exp_r1, exp_r2, exp_res);
            end
            checks++;
            if (obs_done_edge !== 13 + 12 * ack_delay || obs_stab !== 0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got edge=%0d unstable=%0d, want %0d 0", it,
                         obs_done_edge, obs_stab, 13 + 12 * ack_delay);
            end
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (obs_ops[i] != exp_ops[i]) begin
                    errors++;
                    $display("FAIL rand_operands[%0d][%0d]: got %h %h %h, want %h %h %h", it, i,
                             obs_ops[i][0], obs_ops[i][1], obs_ops[i][2],
                             exp_ops[i][0], exp_ops[i][1], exp_ops[i][2]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_wait();
        test_timeout();
        test_busy_ignore();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
